// File: rtl/reg_bank_arbiter_if.sv
// Bundle of requester handshakes (A and B) and register-bank port signals
// used between the control side and the reg_bank_arbiter.
interface reg_bank_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             req_a;
    logic             req_b;
    logic [1:0]       op_a;
    logic [1:0]       op_b;
    logic [AW-1:0]    addr_a;
    logic [AW-1:0]    addr_b;
    logic [AW-1:0]    addr2_a;
    logic [AW-1:0]    addr2_b;
    logic [WIDTH-1:0] wdata_a;
    logic [WIDTH-1:0] wdata_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             done_a;
    logic             done_b;
    logic [WIDTH-1:0] rdata;
    logic             busy;
    logic [AW-1:0]    rId;
    logic [WIDTH-1:0] rIn;
    logic             ldR;
    logic [WIDTH-1:0] rOut;

    // Control unit plus register bank side
    modport master (
        output req_a, req_b, op_a, op_b, addr_a, addr_b, addr2_a, addr2_b,
               wdata_a, wdata_b, rOut,
        input  gnt_a, gnt_b, done_a, done_b, rdata, busy, rId, rIn, ldR
    );

    modport slave (
        input  req_a, req_b, op_a, op_b, addr_a, addr_b, addr2_a, addr2_b,
               wdata_a, wdata_b, rOut,
        output gnt_a, gnt_b, done_a, done_b, rdata, busy, rId, rIn, ldR
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin sequencer serialising read/write/copy commands from two
// requesters onto the single-select register bank port.
module reg_bank_arbiter #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               reset,
    reg_bank_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD, WR, CP1, CP2} state_t;

    state_t           state_reg, state_next;
    logic             prio_b_reg, prio_b_next;
    logic             who_reg, who_next;
    logic [AW-1:0]    addr2_reg, addr2_next;
    logic [WIDTH-1:0] hold_reg, hold_next;
    logic [WIDTH-1:0] rdata_reg, rdata_next;
    logic [AW-1:0]    rid_reg, rid_next;
    logic [WIDTH-1:0] rin_reg, rin_next;
    logic             ldr_reg, ldr_next;
    logic             gnt_a_reg, gnt_a_next, gnt_b_reg, gnt_b_next;
    logic             done_a_reg, done_a_next, done_b_reg, done_b_next;

    // A requester is ignored during its own done cycle so a held req is not re-granted
    logic             req_a_eff, req_b_eff, win_any, win_b;
    logic [1:0]       win_op;
    logic [AW-1:0]    win_addr, win_addr2;
    logic [WIDTH-1:0] win_wdata;

    assign req_a_eff = bus.req_a & ~done_a_reg;
    assign req_b_eff = bus.req_b & ~done_b_reg;
    assign win_any   = req_a_eff | req_b_eff;
    assign win_b     = req_b_eff & (~req_a_eff | prio_b_reg);
    assign win_op    = win_b ? bus.op_b    : bus.op_a;
    assign win_addr  = win_b ? bus.addr_b  : bus.addr_a;
    assign win_addr2 = win_b ? bus.addr2_b : bus.addr2_a;
    assign win_wdata = win_b ? bus.wdata_b : bus.wdata_a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            prio_b_reg <= 1'b0;
            who_reg    <= 1'b0;
            addr2_reg  <= '0;
            hold_reg   <= '0;
            rdata_reg  <= '0;
            rid_reg    <= '0;
            rin_reg    <= '0;
            ldr_reg    <= 1'b0;
            gnt_a_reg  <= 1'b0;
            gnt_b_reg  <= 1'b0;
            done_a_reg <= 1'b0;
            done_b_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            prio_b_reg <= prio_b_next;
            who_reg    <= who_next;
            addr2_reg  <= addr2_next;
            hold_reg   <= hold_next;
            rdata_reg  <= rdata_next;
            rid_reg    <= rid_next;
            rin_reg    <= rin_next;
            ldr_reg    <= ldr_next;
            gnt_a_reg  <= gnt_a_next;
            gnt_b_reg  <= gnt_b_next;
            done_a_reg <= done_a_next;
            done_b_reg <= done_b_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (win_any) begin
                    case (win_op)
                        2'b01:   state_next = WR;
                        2'b10:   state_next = CP1;
                        default: state_next = RD;
                    endcase
                end
            end
            CP1:     state_next = CP2;
            default: state_next = IDLE;
        endcase
    end

    // Computes the values the output flops take on the edge entering the next state
    always_comb begin
        prio_b_next = prio_b_reg;
        who_next    = who_reg;
        addr2_next  = addr2_reg;
        hold_next   = hold_reg;
        rdata_next  = rdata_reg;
        rid_next    = rid_reg;
        rin_next    = rin_reg;
        ldr_next    = 1'b0;
        gnt_a_next  = 1'b0;
        gnt_b_next  = 1'b0;
        done_a_next = 1'b0;
        done_b_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (win_any) begin
                    prio_b_next = ~win_b;
                    who_next    = win_b;
                    addr2_next  = win_addr2;
                    rid_next    = win_addr;
                    gnt_a_next  = ~win_b;
                    gnt_b_next  = win_b;
                    if (win_op == 2'b01) begin
                        rin_next = win_wdata;
                        ldr_next = 1'b1;
                    end
                end
            end
            RD: begin
                rdata_next  = bus.rOut;
                done_a_next = ~who_reg;
                done_b_next = who_reg;
            end
            WR: begin
                done_a_next = ~who_reg;
                done_b_next = who_reg;
            end
            CP1: begin
                hold_next = bus.rOut;
                rid_next  = addr2_reg;
                rin_next  = bus.rOut;
                ldr_next  = 1'b1;
            end
            CP2: begin
                rdata_next  = hold_reg;
                done_a_next = ~who_reg;
                done_b_next = who_reg;
            end
            default: ;
        endcase
    end

    assign bus.gnt_a  = gnt_a_reg;
    assign bus.gnt_b  = gnt_b_reg;
    assign bus.done_a = done_a_reg;
    assign bus.done_b = done_b_reg;
    assign bus.rdata  = rdata_reg;
    assign bus.busy   = (state_reg != IDLE);
    assign bus.rId    = rid_reg;
    assign bus.rIn    = rin_reg;
    assign bus.ldR    = ldr_reg;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: table of single-requester commands
// against a behavioural 8x16 bank, plus arbitration and reset sequences.
module tb_reg_bank_arbiter;
    localparam int WIDTH = 16;
    localparam int AW    = 3;

    typedef struct {
        bit         side;      // 0 = A, 1 = B
        logic [1:0] op;
        logic [2:0] addr;
        logic [2:0] addr2;
        logic [15:0] wdata;
        int         lat;
        int         ld_cnt;
        logic [2:0] ld_id;
        logic [15:0] ld_data;
        logic [15:0] rdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic bank_clr = 1'b1;
    logic [WIDTH-1:0] bank [8];
    int tests = 0;
    int fails = 0;

    reg_bank_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus();

    reg_bank_arbiter #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.rOut = bank[bus.rId];

    always @(posedge clk) begin
        if (bank_clr) begin
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else if (bus.ldR) begin
            bank[bus.rId] <= bus.rIn;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input bit side, input logic [1:0] op, input logic [2:0] addr,
                           input logic [2:0] addr2, input logic [15:0] wdata,
                           output int lat, output int ld_cnt, output logic [2:0] ld_id,
                           output logic [15:0] ld_data, output logic [2:0] first_id,
                           output int gnt_first, output int gnt_cnt, output int wrong);
        @(negedge clk);
        if (side) begin
            bus.req_b = 1'b1; bus.op_b = op; bus.addr_b = addr; bus.addr2_b = addr2; bus.wdata_b = wdata;
        end else begin
            bus.req_a = 1'b1; bus.op_a = op; bus.addr_a = addr; bus.addr2_a = addr2; bus.wdata_a = wdata;
        end
        lat = 0; ld_cnt = 0; ld_id = '0; ld_data = '0; first_id = '0;
        gnt_first = 0; gnt_cnt = 0; wrong = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                first_id  = bus.rId;
                gnt_first = int'(side ? bus.gnt_b : bus.gnt_a);
            end
            if (bus.ldR) begin
                ld_cnt++;
                ld_id   = bus.rId;
                ld_data = bus.rIn;
            end
            if (side ? bus.gnt_b : bus.gnt_a) gnt_cnt++;
            if (side ? (bus.gnt_a | bus.done_a) : (bus.gnt_b | bus.done_b)) wrong++;
            if (side ? bus.done_b : bus.done_a) begin
                lat = n;
                break;
            end
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        @(posedge clk); #1;
    endtask

    vec_t vecs [10];
    int lat, ld_cnt, gnt_first, gnt_cnt, wrong;
    logic [2:0] ld_id, first_id;
    logic [15:0] ld_data;
    int gnt_order [8];
    int done_order [8];
    int ng, nd, both_cnt, done_seen, busy_left;

    initial begin
        vecs[0] = '{1'b0, 2'b01, 3'd3, 3'd0, 16'hBEEF, 2, 1, 3'd3, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b0, 2'b00, 3'd3, 3'd0, 16'h0000, 2, 0, 3'd0, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b0, 2'b01, 3'd1, 3'd0, 16'h1234, 2, 1, 3'd1, 16'h1234, 16'hBEEF};
        vecs[3] = '{1'b1, 2'b10, 3'd1, 3'd6, 16'h0000, 3, 1, 3'd6, 16'h1234, 16'h1234};
        vecs[4] = '{1'b0, 2'b00, 3'd6, 3'd0, 16'h0000, 2, 0, 3'd0, 16'h0000, 16'h1234};
        vecs[5] = '{1'b1, 2'b01, 3'd5, 3'd0, 16'h00FF, 2, 1, 3'd5, 16'h00FF, 16'h1234};
        vecs[6] = '{1'b0, 2'b10, 3'd5, 3'd5, 16'h0000, 3, 1, 3'd5, 16'h00FF, 16'h00FF};
        vecs[7] = '{1'b1, 2'b00, 3'd5, 3'd0, 16'h0000, 2, 0, 3'd0, 16'h0000, 16'h00FF};
        vecs[8] = '{1'b1, 2'b11, 3'd3, 3'd0, 16'h0000, 2, 0, 3'd0, 16'h0000, 16'hBEEF};
        vecs[9] = '{1'b0, 2'b00, 3'd0, 3'd0, 16'h0000, 2, 0, 3'd0, 16'h0000, 16'h0000};

        bus.req_a = 0; bus.req_b = 0; bus.op_a = 0; bus.op_b = 0;
        bus.addr_a = 0; bus.addr_b = 0; bus.addr2_a = 0; bus.addr2_b = 0;
        bus.wdata_a = 0; bus.wdata_b = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_gnt",  {bus.gnt_a, bus.gnt_b}, 0);
        check("reset_done", {bus.done_a, bus.done_b}, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_ldR",  bus.ldR, 0);
        check("reset_rId",  bus.rId, 0);
        check("reset_rIn",  bus.rIn, 0);
        check("reset_rdata", bus.rdata, 0);
        @(negedge clk);
        reset = 1'b1;
        bank_clr = 1'b0;

        // Table-driven single-requester commands
        for (int v = 0; v < 10; v++) begin
            run_cmd(vecs[v].side, vecs[v].op, vecs[v].addr, vecs[v].addr2, vecs[v].wdata,
                    lat, ld_cnt, ld_id, ld_data, first_id, gnt_first, gnt_cnt, wrong);
            $display("[TB] vec %0d side=%s op=%0d addr=%0d addr2=%0d lat=%0d ldR_cycles=%0d rdata=0x%04h",
                     v, vecs[v].side ? "B" : "A", vecs[v].op, vecs[v].addr, vecs[v].addr2,
                     lat, ld_cnt, bus.rdata);
            check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("v%0d_gnt_first", v), gnt_first, 1);
            check($sformatf("v%0d_gnt_count", v), gnt_cnt, 1);
            check($sformatf("v%0d_other_side", v), wrong, 0);
            check($sformatf("v%0d_first_rId", v), first_id, vecs[v].addr);
            check($sformatf("v%0d_ldR_cycles", v), ld_cnt, vecs[v].ld_cnt);
            if (vecs[v].ld_cnt > 0) begin
                check($sformatf("v%0d_ld_rId", v), ld_id, vecs[v].ld_id);
                check($sformatf("v%0d_ld_rIn", v), ld_data, vecs[v].ld_data);
            end
            check($sformatf("v%0d_rdata", v), bus.rdata, vecs[v].rdata);
            check($sformatf("v%0d_busy_after", v), bus.busy, 0);
        end

        // Reset during CP2 aborts the copy without writing or signalling done
        run_cmd(1'b0, 2'b01, 3'd7, 3'd0, 16'h7777, lat, ld_cnt, ld_id, ld_data, first_id, gnt_first, gnt_cnt, wrong);
        run_cmd(1'b0, 2'b01, 3'd2, 3'd0, 16'hAAAA, lat, ld_cnt, ld_id, ld_data, first_id, gnt_first, gnt_cnt, wrong);
        @(negedge clk);
        bus.req_b = 1'b1; bus.op_b = 2'b10; bus.addr_b = 3'd2; bus.addr2_b = 3'd7;
        @(posedge clk); #1;
        check("cp1_rId", bus.rId, 2);
        check("cp1_ldR", bus.ldR, 0);
        @(posedge clk); #1;
        check("cp2_ldR", bus.ldR, 1);
        check("cp2_rId", bus.rId, 7);
        check("cp2_rIn", bus.rIn, 16'hAAAA);
        #2;
        reset = 1'b0;
        bus.req_b = 1'b0;
        #1;
        check("abort_ldR", bus.ldR, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_rdata", bus.rdata, 0);
        done_seen = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done_a | bus.done_b) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        run_cmd(1'b0, 2'b00, 3'd7, 3'd0, 16'h0000, lat, ld_cnt, ld_id, ld_data, first_id, gnt_first, gnt_cnt, wrong);
        $display("[TB] abort read r7 lat=%0d rdata=0x%04h", lat, bus.rdata);
        check("abort_dest_kept", bus.rdata, 16'h7777);
        check("abort_read_lat", lat, 2);

        // Both requesters holding reads from reset: strict alternation
        @(negedge clk);
        reset = 1'b0;
        bus.req_a = 1'b1; bus.op_a = 2'b00; bus.addr_a = 3'd2;
        bus.req_b = 1'b1; bus.op_b = 2'b00; bus.addr_b = 3'd4;
        for (int i = 0; i < 8; i++) begin
            gnt_order[i] = 9;
            done_order[i] = 9;
        end
        ng = 0; nd = 0; both_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (bus.gnt_a & bus.gnt_b) both_cnt++;
            if (bus.gnt_a && ng < 8) begin gnt_order[ng] = 0; ng++; end
            if (bus.gnt_b && ng < 8) begin gnt_order[ng] = 1; ng++; end
            if (bus.done_a && nd < 8) begin done_order[nd] = 0; nd++; end
            if (bus.done_b && nd < 8) begin done_order[nd] = 1; nd++; end
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        $display("[TB] dual reads: grants=%0d order=%0d%0d%0d%0d dones=%0d", ng,
                 gnt_order[0], gnt_order[1], gnt_order[2], gnt_order[3], nd);
        check("dual_both_gnt", both_cnt, 0);
        check("dual_gnt_count", ng, 6);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dual_gnt_order%0d", i), gnt_order[i], i % 2);
            check($sformatf("dual_done_order%0d", i), done_order[i], i % 2);
        end
        busy_left = 0;
        repeat (3) @(posedge clk);
        #1;
        if (bus.busy) busy_left = 1;
        check("dual_idle_after", busy_left, 0);

        // Lone requester holding req through its done cycle
        @(negedge clk);
        bus.req_a = 1'b1; bus.op_a = 2'b00; bus.addr_a = 3'd3;
        @(posedge clk); #1;
        check("held_gnt_c1", bus.gnt_a, 1);
        @(posedge clk); #1;
        check("held_done_c2", bus.done_a, 1);
        @(posedge clk); #1;
        check("held_gnt_c3_masked", bus.gnt_a, 0);
        check("held_busy_c3", bus.busy, 0);
        @(posedge clk); #1;
        check("held_gnt_c4", bus.gnt_a, 1);
        bus.req_a = 1'b0;
        $display("[TB] held req sequence complete");
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Sequencer and two-port round-robin arbiter for the 8×16 register bank. The bank has a single `rId` select that serves both read and write, so only one access can proceed per cycle. This block serialises read, write and register-to-register copy commands from two requesters, A (decode/operand fetch) and B (ALU writeback), onto that port. It sits between the control unit and the register bank, and it alone drives the bank's `rId`, `rIn` and `ldR`.

## Interface
- WIDTH, 16, register data width
- AW, 3, register address width (8 registers)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_a / req_b  in  1  command request, held until done
- op_a / op_b  in  2  00 read, 01 write, 10 copy (addr → addr2), 11 reserved
- addr_a / addr_b  in  AW  target register (copy: source)
- addr2_a / addr2_b  in  AW  copy destination; ignored otherwise
- wdata_a / wdata_b  in  WIDTH  write data
- gnt_a / gnt_b  out  1  one-cycle pulse: command accepted
- done_a / done_b  out  1  one-cycle pulse: command complete
- rdata  out  WIDTH  read result; valid with done, held until next read completes
- busy  out  1  high in any state other than IDLE
- rId  out  AW  bank select
- rIn  out  WIDTH  bank write data
- ldR  out  1  bank load enable
- rOut  in  WIDTH  bank read data (combinational from rId)

## Operation
- States: IDLE, RD, WR, CP1, CP2.
- IDLE, at a rising edge with an unmasked request:
  - Pick the winner; latch its op, addr, addr2 and wdata.
  - Set the winner's gnt for the next cycle.
  - Go to RD (op 00 or 11), WR (01) or CP1 (10).
- Arbitration is round-robin on one priority bit:
  - A has priority after reset.
  - Each grant passes priority to the other requester.
  - A lone requester always wins.
- Masking: in the cycle done_x is high, req_x is ignored. The requester drops req in that cycle or earlier.
- RD:
  - rId = addr, ldR = 0.
  - At the next edge: rdata ← rOut, done_winner ← 1, go to IDLE.
- WR:
  - rId = addr, rIn = wdata, ldR = 1 for the whole cycle.
  - At the next edge: done ← 1, go to IDLE.
  - rdata is unchanged.
- CP1:
  - rId = addr2's source, i.e. addr, ldR = 0.
  - At the next edge: hold ← rOut, go to CP2.
- CP2:
  - rId = addr2, rIn = hold, ldR = 1.
  - At the next edge: done ← 1, go to IDLE.
  - rdata ← hold (copy also returns the moved value).
- Op 11 behaves exactly as a read.
- Copy with addr == addr2 is legal and rewrites the same value.
- Glitch-free drive: rId, rIn and ldR come directly from flops, set on the edge that enters the state. The bank gates ldR with clk, so these signals must not glitch during the high phase.
- Outside WR/CP2, ldR = 0, and rId/rIn hold their last values.
- Commands never overlap. A request arriving while busy waits until IDLE.

## Timing
- Reset (reset = 0, asynchronous) puts the block in this state:
  - state IDLE, priority A
  - gnt_*, done_*, busy, ldR = 0
  - rId = 0, rIn = 0, rdata = 0, hold = 0
- Reset mid-command aborts the command. No done is issued, and ldR drops immediately.
- Deassertion is synchronised externally. The first edge after deassertion may grant.
- Latency from the edge sampling req to the edge raising done:
  - read/write: 2 edges (gnt cycle = RD/WR cycle)
  - copy: 3 edges
- Throughput:
  - back-to-back reads: one per 2 cycles
  - copies: one per 3 cycles
- gnt is high in the first execute cycle. done is high in the following IDLE cycle.
- Simultaneous new requests from both sides with different priority state resolve strictly by the priority bit.

## Test plan
- Reset, then A write r3 = 0xBEEF, then A read r3:
  - ldR high for exactly 1 cycle with rId = 3.
  - The read gives done_a and rdata = 0xBEEF 2 cycles after req.
- req_a and req_b both asserted from reset, each holding a read:
  - gnt order is A, B, A, B.
  - done pulses alternate.
  - No cycle has both gnt signals high.
- Write r1 = 0x1234, then B copies 1 → 6:
  - CP1 has rId = 1, ldR = 0; CP2 has rId = 6, rIn = 0x1234, ldR = 1.
  - done_b arrives 3 edges after sampling, with rdata = 0x1234.
  - A later read of r6 returns 0x1234.
- Copy 5 → 5 with r5 = 0x00FF leaves r5 = 0x00FF and completes in 3 cycles.
- Assert reset during CP2:
  - ldR = 0 immediately, and no done.
  - After release, a read of the destination returns its old value (0 after a full bank reset).
- Requester holds req through its done cycle:
  - It is not re-granted for that cycle.
  - A later held req is granted only at the next IDLE edge.
